uart_rx_frontend: RTL and testbench

UART receiver that deserialises the host serial line into bytes. It feeds the memory-access command engine with RX_data and a one-cycle byte_done strobe. The line is 8N1 and LSB first, sampled with 16x oversampling and 3-sample majority voting. RX_data holds its value between bytes because the downstream engine decodes command bytes (0x0F write, 0xFF read) level-sensitively while idle.

---
 rtl/uart_rx_frontend.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling with 3-sample majority vote.
// Delivers each well-framed byte on RX_data (held) with a one-cycle byte_done strobe.
module uart_rx_frontend #(
    parameter int TICK_DIV   = 54,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] RX_data,
    output logic       byte_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int            TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [3:0]    S_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_SMP_A   = 4'd7;
    localparam logic [3:0]    S_SMP_B   = 4'd8;
    localparam logic [3:0]    S_DECIDE  = 4'd9;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t        state_r;
    logic          sync1_r;
    logic          sync2_r;
    logic          prev_r;
    logic [TW-1:0] tick_cnt_r;
    logic [3:0]    s_cnt_r;
    logic [2:0]    bit_idx_r;
    logic          smp_a_r;
    logic          smp_b_r;
    logic [7:0]    shift_r;
    logic          rx_s;
    logic          fall_s;
    logic          tick_s;
    logic          maj_s;
    logic          decide_s;
    logic          bit_end_s;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign rx_s      = sync2_r;
    assign fall_s    = prev_r & ~rx_s;
    assign tick_s    = (state_r != IDLE) && (tick_cnt_r == TICK_MAX);
    // Third vote is the live synchronised sample taken on the s = 9 tick itself.
    assign maj_s     = majority3(smp_a_r, smp_b_r, rx_s);
    assign decide_s  = tick_s && (s_cnt_r == S_DECIDE);
    assign bit_end_s = tick_s && (s_cnt_r == S_LAST);

    // Synchroniser, oversample timing, receive FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            prev_r     <= 1'b1;
            tick_cnt_r <= {TW{1'b0}};
            s_cnt_r    <= 4'd0;
            bit_idx_r  <= 3'd0;
            smp_a_r    <= 1'b0;
            smp_b_r    <= 1'b0;
            shift_r    <= 8'h00;
            RX_data    <= 8'h00;
            byte_done  <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            sync1_r   <= rx;
            sync2_r   <= sync1_r;
            prev_r    <= rx_s;
            byte_done <= 1'b0;
            frame_err <= 1'b0;

            // Tick counter is parked at 0 in IDLE so its phase follows the start edge.
            if ((state_r == IDLE) || tick_s) begin
                tick_cnt_r <= {TW{1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end

            if (tick_s) begin
                s_cnt_r <= (s_cnt_r == S_LAST) ? 4'd0 : (s_cnt_r + 4'd1);
                if (s_cnt_r == S_SMP_A) begin
                    smp_a_r <= rx_s;
                end
                if (s_cnt_r == S_SMP_B) begin
                    smp_b_r <= rx_s;
                end
            end

            case (state_r)
                IDLE: begin
                    s_cnt_r <= 4'd0;
                    if (fall_s) begin
                        state_r <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (decide_s && maj_s) begin
                        state_r <= IDLE;
                        rx_busy <= 1'b0;
                    end else if (bit_end_s) begin
                        state_r   <= DATA;
                        bit_idx_r <= 3'd0;
                    end
                end
                DATA: begin
                    if (decide_s) begin
                        shift_r <= {maj_s, shift_r[7:1]};
                    end
                    if (bit_end_s) begin
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                // Stop bit is judged mid-bit so a new start edge can follow immediately.
                STOP: begin
                    if (decide_s) begin
                        if (maj_s) begin
                            RX_data   <= shift_r;
                            byte_done <= 1'b1;
                            state_r   <= IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: serial frames are generated at bit level and the
// received byte stream is scored against a queue of the bytes that were sent.
module tb_uart_rx_frontend;

    localparam int TDIV   = 4;
    localparam int BIT_P  = 16 * TDIV;
    localparam int BIT_HI = 66;
    localparam int BIT_LO = 62;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] RX_data;
    logic       byte_done;
    logic       frame_err;
    logic       rx_busy;

    int         checks;
    int         failures;
    int         bd_seen;
    int         fe_seen;
    int         exp_fe;
    int         sent_ok;
    logic [7:0] exp_q[$];
    logic       mon_en;
    logic       rst_d;
    logic       prev_bd;
    logic       prev_fe;
    logic [7:0] last_data;

    uart_rx_frontend #(.TICK_DIV(TDIV), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .RX_data   (RX_data),
        .byte_done (byte_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one 8N1 frame LSB first; abort_pos >= 0 pulses reset inside that bit slot.
    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_val,
                              input int abort_pos);
        logic [9:0] bits_v;
        bits_v = {stop_val, b, 1'b0};
        if (stop_val && (abort_pos < 0)) begin
            exp_q.push_back(b);
            sent_ok++;
        end
        if (!stop_val) exp_fe++;
        for (int k = 0; k < 10; k++) begin
            rx = bits_v[k];
            if (k == abort_pos) begin
                repeat (period / 2) @(negedge clk);
                rst_n = 1'b0;
                rx    = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat (period) @(negedge clk);
        end
    endtask

    always @(posedge clk) rst_d <= rst_n;

    // Scoreboard: every byte_done must match the oldest outstanding sent byte.
    always @(negedge clk) begin
        if (mon_en) begin
            if (byte_done) begin
                bd_seen++;
                check_eq("bd_fe_overlap", {31'd0, frame_err}, 32'd0);
                check_eq("bd_width", {31'd0, prev_bd}, 32'd0);
                check_eq("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check_eq("rx_data", {24'd0, RX_data}, {24'd0, exp_q.pop_front()});
            end else if (rst_d) begin
                check_eq("rx_data_hold", {24'd0, RX_data}, {24'd0, last_data});
            end
            if (frame_err) begin
                fe_seen++;
                check_eq("fe_width", {31'd0, prev_fe}, 32'd0);
            end
        end
        prev_bd   = byte_done;
        prev_fe   = frame_err;
        last_data = RX_data;
    end

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bd0;
        int fe0;
        logic [7:0] rb;
        checks   = 0;
        failures = 0;
        bd_seen  = 0;
        fe_seen  = 0;
        exp_fe   = 0;
        sent_ok  = 0;
        mon_en   = 1'b0;
        rx       = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_rx_data", {24'd0, RX_data}, 32'd0);
        check_eq("rst_byte_done", {31'd0, byte_done}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        // 1: single command byte
        bd0 = bd_seen; fe0 = fe_seen;
        send_frame(8'h0F, BIT_P, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t1_count", bd_seen - bd0, 32'd1);
        check_eq("t1_data", {24'd0, RX_data}, 32'h0F);
        check_eq("t1_fe", fe_seen - fe0, 32'd0);

        // 2: back-to-back frames with no idle gap
        bd0 = bd_seen; fe0 = fe_seen;
        send_frame(8'hFF, BIT_P, 1'b1, -1);
        send_frame(8'h00, BIT_P, 1'b1, -1);
        send_frame(8'hA5, BIT_P, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t2_count", bd_seen - bd0, 32'd3);
        check_eq("t2_data", {24'd0, RX_data}, 32'hA5);
        check_eq("t2_fe", fe_seen - fe0, 32'd0);

        // 3: short low glitch is rejected as a false start
        bd0 = bd_seen; fe0 = fe_seen;
        rx = 1'b0;
        repeat (3 * TDIV) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_P) @(negedge clk);
        check_eq("t3_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("t3_count", bd_seen - bd0, 32'd0);
        check_eq("t3_fe", fe_seen - fe0, 32'd0);
        send_frame(8'h3C, BIT_P, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t3_data", {24'd0, RX_data}, 32'h3C);

        // 4: bad stop bit followed by a held break
        send_frame(8'hA5, BIT_P, 1'b1, -1);
        bd0 = bd_seen; fe0 = fe_seen;
        send_frame(8'h55, BIT_P, 1'b0, -1);
        repeat (20 * BIT_P) @(negedge clk);
        check_eq("t4_fe", fe_seen - fe0, 32'd1);
        check_eq("t4_count", bd_seen - bd0, 32'd0);
        check_eq("t4_data", {24'd0, RX_data}, 32'hA5);
        check_eq("t4_busy_hi", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("t4_busy_lo", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h81, BIT_P, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t4_next", {24'd0, RX_data}, 32'h81);

        // 5: +/-3% baud error
        bd0 = bd_seen; fe0 = fe_seen;
        send_frame(8'h5A, BIT_LO, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t5_fast", {24'd0, RX_data}, 32'h5A);
        send_frame(8'h5A, BIT_HI, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t5_count", bd_seen - bd0, 32'd2);
        check_eq("t5_fe", fe_seen - fe0, 32'd0);

        // 6: reset during data bit 4 aborts silently
        bd0 = bd_seen; fe0 = fe_seen;
        send_frame(8'hC3, BIT_P, 1'b1, 5);
        check_eq("t6_rst_data", {24'd0, RX_data}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("t6_rst_bd", {31'd0, byte_done}, 32'd0);
        check_eq("t6_rst_fe", {31'd0, frame_err}, 32'd0);
        repeat (8 * BIT_P) @(negedge clk);
        check_eq("t6_no_pulse", (bd_seen - bd0) + (fe_seen - fe0), 32'd0);
        send_frame(8'h0F, BIT_P, 1'b1, -1);
        repeat (BIT_P) @(negedge clk);
        check_eq("t6_data", {24'd0, RX_data}, 32'h0F);

        // Randomized bytes, baud within +/-3% and random idle gaps
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, int'($urandom_range(BIT_LO, BIT_HI)), 1'b1, -1);
            repeat ($urandom_range(0, 2 * BIT_P)) @(negedge clk);
        end
        repeat (2 * BIT_P) @(negedge clk);

        check_eq("queue_drained", exp_q.size(), 32'd0);
        check_eq("total_bytes", bd_seen, sent_ok);
        check_eq("total_fe", fe_seen, exp_fe);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
